// File: rtl/seq_sink_if.sv
// Valid/ready stream bundle between an upstream sender (master) and the seq_sink consumer (slave).
interface seq_sink_if #(
    parameter int DW = 32
);
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          up_ready;

    modport master (output up_valid, output up_data, input up_ready);
    modport slave  (input up_valid, input up_data, output up_ready);
endinterface

// File: rtl/seq_sink.sv
// Stream sink: programmable back-pressure, incrementing-sequence checker, saturating counters.
// Optional handshake-violation detector enabled by defining SEQ_SINK_PROTO_CHECK_EN.
module seq_sink #(
    parameter int            DW    = 32,
    parameter int            DELAY = 0,
    parameter logic [DW-1:0] START = '0,
    parameter int            CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    seq_sink_if.slave        up,
    output logic [DW-1:0]    expected,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic [DW-1:0]    first_bad,
    output logic             proto_err
);
    localparam int               HW        = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int               HOLD_INIT = (DELAY > 0) ? DELAY - 1 : 0;
    localparam bit               USE_HOLD  = (DELAY > 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {RDY, HOLD} state_t;

    state_t        state_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic          ready_reg;
    logic [DW-1:0] expected_reg;
    logic [DW-1:0] first_bad_reg;
    logic          err_reg;
    logic          accept;
    logic          match;
    logic [1:0]    cnt_inc;

    assign accept      = up.up_valid & ready_reg;
    assign match       = (up.up_data == expected_reg);
    assign up.up_ready = ready_reg;

    // ready is low during reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RDY;
            hold_cnt_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                RDY: begin
                    if (accept && USE_HOLD) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= HW'(HOLD_INIT);
                        ready_reg    <= 1'b0;
                    end else begin
                        ready_reg    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_reg <= RDY;
                        ready_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= RDY;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // A mismatch resynchronises to the received word so one dropped word is one error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected_reg  <= START;
            err_reg       <= 1'b0;
            first_bad_reg <= '0;
        end else if (accept) begin
            expected_reg <= (match ? expected_reg : up.up_data) + 1'b1;
            if (!match) begin
                err_reg <= 1'b1;
                if (!err_reg) begin
                    first_bad_reg <= up.up_data;
                end
            end
        end
    end

    assign cnt_inc = {accept & ~match, accept};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign expected  = expected_reg;
    assign beat_cnt  = g_cnt[0].cnt_reg;
    assign err_cnt   = g_cnt[1].cnt_reg;
    assign err       = err_reg;
    assign first_bad = first_bad_reg;

`ifdef SEQ_SINK_PROTO_CHECK_EN
    logic          stalled_reg;
    logic [DW-1:0] stalled_data_reg;
    logic          proto_err_reg;

    // A stalled beat must stay valid with unchanged payload on the following cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalled_reg      <= 1'b0;
            stalled_data_reg <= '0;
            proto_err_reg    <= 1'b0;
        end else begin
            stalled_reg      <= up.up_valid & ~ready_reg;
            stalled_data_reg <= up.up_data;
            if (stalled_reg && (!up.up_valid || (up.up_data != stalled_data_reg))) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_reg;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_sink.sv
// Scoreboard bench for seq_sink: four instances covering back-to-back, hold delay, wrap/saturation,
// reset mid-hold and the handshake check (expectation follows SEQ_SINK_PROTO_CHECK_EN).
`timescale 1ns/1ps
module tb_seq_sink;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] exp;
        logic [15:0] beat;
        logic [15:0] errc;
        logic        err;
        logic [31:0] fb;
    } obs_t;

`ifdef SEQ_SINK_PROTO_CHECK_EN
    localparam logic PROTO_EXP = 1'b1;
`else
    localparam logic PROTO_EXP = 1'b0;
`endif

    seq_sink_if #(.DW(32)) if0 ();
    seq_sink_if #(.DW(32)) if2 ();
    seq_sink_if #(.DW(32)) ifw ();
    seq_sink_if #(.DW(32)) if1 ();

    logic [31:0] e0, f0, e2, f2, ew, fw, e1, f1;
    logic [15:0] b0, c0, b2, c2, b1, c1;
    logic [3:0]  bw, cw;
    logic        r0, r2, rw, r1, p0, p2, pw, p1;

    seq_sink #(.DW(32), .DELAY(0), .START(32'h0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .up(if0), .expected(e0), .beat_cnt(b0),
        .err_cnt(c0), .err(r0), .first_bad(f0), .proto_err(p0));
    seq_sink #(.DW(32), .DELAY(2), .START(32'h0), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .up(if2), .expected(e2), .beat_cnt(b2),
        .err_cnt(c2), .err(r2), .first_bad(f2), .proto_err(p2));
    seq_sink #(.DW(32), .DELAY(0), .START(32'hFFFF_FFFE), .CNT_W(4)) uw (
        .clk(clk), .rst(rst), .up(ifw), .expected(ew), .beat_cnt(bw),
        .err_cnt(cw), .err(rw), .first_bad(fw), .proto_err(pw));
    seq_sink #(.DW(32), .DELAY(1), .START(32'h0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .up(if1), .expected(e1), .beat_cnt(b1),
        .err_cnt(c1), .err(r1), .first_bad(f1), .proto_err(p1));

    obs_t        sb[$];
    obs_t        got, want;
    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] m_exp, m_fb;
    int unsigned m_beat, m_errc;
    logic        m_err;

    function automatic obs_t mk(input logic [31:0] e, input logic [15:0] b, input logic [15:0] c,
                                input logic r, input logic [31:0] f);
        obs_t o;
        o.exp = e; o.beat = b; o.errc = c; o.err = r; o.fb = f;
        return o;
    endfunction

    task automatic model_reset(input logic [31:0] start);
        m_exp = start; m_fb = '0; m_beat = 0; m_errc = 0; m_err = 1'b0;
        sb.delete();
    endtask

    // Reference behaviour for one accepted beat; result is due one cycle later
    task automatic model_beat(input logic [31:0] d, input int cnt_w);
        int unsigned cmax;
        cmax = (32'd1 << cnt_w) - 1;
        if (d == m_exp) begin
            m_exp = m_exp + 1;
        end else begin
            if (m_errc < cmax) m_errc = m_errc + 1;
            if (!m_err) m_fb = d;
            m_err = 1'b1;
            m_exp = d + 1;
        end
        if (m_beat < cmax) m_beat = m_beat + 1;
        sb.push_back(mk(m_exp, 16'(m_beat), 16'(m_errc), m_err, m_fb));
    endtask

    task automatic drive_idle();
        if0.up_valid = 1'b0; if0.up_data = '0;
        if2.up_valid = 1'b0; if2.up_data = '0;
        ifw.up_valid = 1'b0; ifw.up_data = '0;
        if1.up_valid = 1'b0; if1.up_data = '0;
    endtask

    // Returns at the first falling edge where up_ready is already high again
    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        got = mk(e0, b0, c0, r0, f0);
        ncmp++;
        if (got !== mk(32'h0, 16'h0, 16'h0, 1'b0, 32'h0)) begin
            nfail++;
            $display("FAIL reset_u0 got %h required %h", got, mk(32'h0, 16'h0, 16'h0, 1'b0, 32'h0));
        end
        ncmp++;
        if ({if0.up_ready, if2.up_ready, ifw.up_ready, if1.up_ready} !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_ready got %b required 0000",
                     {if0.up_ready, if2.up_ready, ifw.up_ready, if1.up_ready});
        end
        ncmp++;
        if (ew !== 32'hFFFF_FFFE) begin
            nfail++;
            $display("FAIL reset_start got %h required fffffffe", ew);
        end
        ncmp++;
        if ({p0, p2, pw, p1} !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_proto got %b required 0000", {p0, p2, pw, p1});
        end
        rst = 1'b1;
        @(negedge clk);
        ncmp++;
        if ({if0.up_ready, if2.up_ready} !== 2'b11) begin
            nfail++;
            $display("FAIL ready_rise got %b required 11", {if0.up_ready, if2.up_ready});
        end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        model_reset(32'h0);
        for (int i = 0; i <= 100; i++) begin
            ncmp++;
            if (if0.up_ready !== 1'b1) begin
                nfail++;
                $display("FAIL b2b_ready cycle %0d got %b required 1", i, if0.up_ready);
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(e0, b0, c0, r0, f0);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL b2b_beat got exp=%h beat=%0d errc=%0d err=%b fb=%h required exp=%h beat=%0d errc=%0d err=%b fb=%h",
                             got.exp, got.beat, got.errc, got.err, got.fb,
                             want.exp, want.beat, want.errc, want.err, want.fb);
                end else begin
                    $display("b2b beat exp=%h beat=%0d errc=%0d", got.exp, got.beat, got.errc);
                end
            end
            if (i < 100) begin
                if0.up_valid = 1'b1;
                if0.up_data  = i;
                model_beat(i, 16);
            end else begin
                if0.up_valid = 1'b0;
            end
            @(negedge clk);
        end
        got = mk(e0, b0, c0, r0, f0);
        ncmp++;
        if (got !== mk(32'd100, 16'd100, 16'd0, 1'b0, 32'h0)) begin
            nfail++;
            $display("FAIL b2b_final got %h required %h", got, mk(32'd100, 16'd100, 16'd0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] seq [6];
        seq = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd7};
        do_reset();
        model_reset(32'h0);
        for (int i = 0; i <= 6; i++) begin
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(e0, b0, c0, r0, f0);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL mismatch_beat got exp=%h beat=%0d errc=%0d err=%b fb=%h required exp=%h beat=%0d errc=%0d err=%b fb=%h",
                             got.exp, got.beat, got.errc, got.err, got.fb,
                             want.exp, want.beat, want.errc, want.err, want.fb);
                end else begin
                    $display("mismatch beat exp=%h beat=%0d errc=%0d fb=%h", got.exp, got.beat, got.errc, got.fb);
                end
            end
            if (i < 6) begin
                if0.up_valid = 1'b1;
                if0.up_data  = seq[i];
                model_beat(seq[i], 16);
            end else begin
                if0.up_valid = 1'b0;
            end
            @(negedge clk);
        end
        got = mk(e0, b0, c0, r0, f0);
        ncmp++;
        if (got !== mk(32'd8, 16'd6, 16'd2, 1'b1, 32'd4)) begin
            nfail++;
            $display("FAIL mismatch_final got %h required %h", got, mk(32'd8, 16'd6, 16'd2, 1'b1, 32'd4));
        end
    endtask

    task automatic test_hold_delay();
        int nb;
        do_reset();
        model_reset(32'h0);
        nb = 0;
        for (int k = 0; k <= 30; k++) begin
            ncmp++;
            if (if2.up_ready !== ((k % 3) == 0)) begin
                nfail++;
                $display("FAIL hold_ready cycle %0d got %b required %b", k, if2.up_ready, ((k % 3) == 0));
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(e2, b2, c2, r2, f2);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL hold_beat got %h required %h", got, want);
                end else begin
                    $display("hold beat exp=%h beat=%0d", got.exp, got.beat);
                end
            end
            if (k < 30) begin
                if2.up_valid = 1'b1;
                if2.up_data  = nb;
                if ((k % 3) == 0) begin
                    model_beat(nb, 16);
                    nb++;
                end
            end else begin
                if2.up_valid = 1'b0;
            end
            @(negedge clk);
        end
        got = mk(e2, b2, c2, r2, f2);
        ncmp++;
        if (got !== mk(32'd10, 16'd10, 16'd0, 1'b0, 32'h0)) begin
            nfail++;
            $display("FAIL hold_final got %h required %h", got, mk(32'd10, 16'd10, 16'd0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_wrap_saturate();
        logic [31:0] d;
        do_reset();
        model_reset(32'hFFFF_FFFE);
        for (int i = 0; i <= 20; i++) begin
            ncmp++;
            if (ifw.up_ready !== 1'b1) begin
                nfail++;
                $display("FAIL wrap_ready cycle %0d got %b required 1", i, ifw.up_ready);
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(ew, 16'(bw), 16'(cw), rw, fw);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL wrap_beat got exp=%h beat=%0d errc=%0d err=%b required exp=%h beat=%0d errc=%0d err=%b",
                             got.exp, got.beat, got.errc, got.err, want.exp, want.beat, want.errc, want.err);
                end else begin
                    $display("wrap beat exp=%h beat=%0d", got.exp, got.beat);
                end
            end
            if (i == 4) begin
                ncmp++;
                if ({ew, rw} !== {32'd2, 1'b0}) begin
                    nfail++;
                    $display("FAIL wrap_after4 got exp=%h err=%b required exp=00000002 err=0", ew, rw);
                end
            end
            if (i < 20) begin
                d = 32'hFFFF_FFFE + i;
                ifw.up_valid = 1'b1;
                ifw.up_data  = d;
                model_beat(d, 4);
            end else begin
                ifw.up_valid = 1'b0;
            end
            @(negedge clk);
        end
        ncmp++;
        if ({bw, cw, ew} !== {4'd15, 4'd0, 32'd18}) begin
            nfail++;
            $display("FAIL sat_beat got beat=%0d errc=%0d exp=%h required beat=15 errc=0 exp=00000012", bw, cw, ew);
        end
        // mismatch on a saturated beat counter
        ifw.up_valid = 1'b1;
        ifw.up_data  = 32'h100;
        model_beat(32'h100, 4);
        @(negedge clk);
        ifw.up_valid = 1'b0;
        want = sb.pop_front();
        got  = mk(ew, 16'(bw), 16'(cw), rw, fw);
        ncmp++;
        if (got !== want || got !== mk(32'h101, 16'd15, 16'd1, 1'b1, 32'h100)) begin
            nfail++;
            $display("FAIL sat_mismatch got %h required %h", got, mk(32'h101, 16'd15, 16'd1, 1'b1, 32'h100));
        end else begin
            $display("sat mismatch beat exp=%h beat=%0d errc=%0d fb=%h", got.exp, got.beat, got.errc, got.fb);
        end
    endtask

    task automatic test_reset_mid_hold();
        int nb;
        do_reset();
        model_reset(32'h0);
        nb = 0;
        for (int k = 0; k <= 13; k++) begin
            ncmp++;
            if (if2.up_ready !== ((k % 3) == 0)) begin
                nfail++;
                $display("FAIL rsthold_ready cycle %0d got %b required %b", k, if2.up_ready, ((k % 3) == 0));
            end
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(e2, b2, c2, r2, f2);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL rsthold_beat got %h required %h", got, want);
                end else begin
                    $display("rsthold beat exp=%h beat=%0d", got.exp, got.beat);
                end
            end
            if (k < 13) begin
                if2.up_valid = 1'b1;
                if2.up_data  = nb;
                if ((k % 3) == 0) begin
                    model_beat(nb, 16);
                    nb++;
                end
                @(negedge clk);
            end
        end
        // now mid-HOLD after the fifth beat
        rst = 1'b0;
        #1;
        got = mk(e2, b2, c2, r2, f2);
        ncmp++;
        if (got !== mk(32'h0, 16'h0, 16'h0, 1'b0, 32'h0) || if2.up_ready !== 1'b0 || p2 !== 1'b0) begin
            nfail++;
            $display("FAIL rsthold_async got %h ready=%b proto=%b required %h ready=0 proto=0",
                     got, if2.up_ready, p2, mk(32'h0, 16'h0, 16'h0, 1'b0, 32'h0));
        end
        if2.up_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset(32'h0);
        nb = 0;
        for (int k = 0; k <= 12; k++) begin
            if (sb.size() != 0) begin
                want = sb.pop_front();
                got  = mk(e2, b2, c2, r2, f2);
                ncmp++;
                if (got !== want) begin
                    nfail++;
                    $display("FAIL rsthold_after got %h required %h", got, want);
                end else begin
                    $display("rsthold after beat exp=%h beat=%0d", got.exp, got.beat);
                end
            end
            if2.up_valid = (nb < 4);
            if2.up_data  = nb;
            if (((k % 3) == 0) && (nb < 4)) begin
                model_beat(nb, 16);
                nb++;
            end
            @(negedge clk);
        end
        if2.up_valid = 1'b0;
        got = mk(e2, b2, c2, r2, f2);
        ncmp++;
        if (got !== mk(32'd4, 16'd4, 16'd0, 1'b0, 32'h0)) begin
            nfail++;
            $display("FAIL rsthold_final got %h required %h", got, mk(32'd4, 16'd4, 16'd0, 1'b0, 32'h0));
        end
    endtask

    task automatic test_proto();
        logic [4:0]  rexp;
        logic [31:0] dat [5];
        rexp = 5'b10101;
        dat  = '{32'd4, 32'd5, 32'd5, 32'd6, 32'd7};
        do_reset();
        for (int n = 0; n < 5; n++) begin
            ncmp++;
            if (if1.up_ready !== rexp[4-n]) begin
                nfail++;
                $display("FAIL proto_ready cycle %0d got %b required %b", n, if1.up_ready, rexp[4-n]);
            end
            if (n == 3) begin
                ncmp++;
                if (p1 !== 1'b0) begin
                    nfail++;
                    $display("FAIL proto_legal_stall got %b required 0", p1);
                end
            end
            if1.up_valid = 1'b1;
            if1.up_data  = dat[n];
            $display("proto drive cycle %0d data=%0d ready=%b", n, dat[n], if1.up_ready);
            @(negedge clk);
        end
        if1.up_valid = 1'b0;
        ncmp++;
        if (p1 !== PROTO_EXP) begin
            nfail++;
            $display("FAIL proto_violation got %b required %b", p1, PROTO_EXP);
        end
        @(negedge clk);
        ncmp++;
        if (p1 !== PROTO_EXP) begin
            nfail++;
            $display("FAIL proto_sticky got %b required %b", p1, PROTO_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mismatch();
        test_hold_delay();
        test_wrap_saturate();
        test_reset_mid_hold();
        test_proto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
